// File: rtl/acc16_seq.sv
// Sums a burst of LEN operands from a valid/ready stream and reports the 16-bit total plus a sticky carry-out.
// Latency: the result is valid the cycle after the final accepted operand; an empty burst completes one cycle after start.
// Backpressure: in_ready is high only while accumulating, and the result is held in DONE until out_ready is seen.

module fullAdder16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);
    logic [16:0] c;

    assign c[0] = cin_i;

    // One full-adder cell per bit; the carry ripples from bit 0 to bit 15.
    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[16];
endmodule

module acc16_seq #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    // The adder is always looking at acc + in_data; its result is only taken on a beat.
    fullAdder16 u_add (
        .a_i    (acc_q),
        .b_i    (in_data),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // State and datapath registers; reset drops any partial burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            carry_q <= carry_d;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        carry_d   = carry_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    if (len != '0) begin
                        len_d   = len;
                        cnt_d   = '0;
                        state_d = S_ACCUM;
                    end else begin
                        // Empty burst goes straight to a zero result.
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = add_sum;
                    carry_d = carry_q | add_cout;
                    cnt_d   = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The result registers double as the output; they stay put in IDLE until the next start.
    assign out_sum   = acc_q;
    assign out_carry = carry_q;
    assign busy      = (state_q != S_IDLE);
endmodule
